// File: rtl/check_sequencer_pkg.sv
// Shared types and constants for the check_sequencer block: FSM states,
// LFSR feedback taps, scoreboard widths and the stimulus rotation helpers.
package check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Feedback taps 64,63,61,60 counted from 1, i.e. state bits 63,62,60,59.
  localparam logic [63:0] LFSR_TAPS  = 64'hD800_0000_0000_0000;
  localparam int          ERR_CNT_W  = 16;
  localparam logic [ERR_CNT_W-1:0] NO_ERR_IDX = 16'hFFFF;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [63:0] rot32(input logic [63:0] s);
    return {s[31:0], s[63:32]};
  endfunction

  function automatic logic [63:0] rotl1(input logic [63:0] s);
    return {s[62:0], s[63]};
  endfunction

endpackage

// File: rtl/check_sequencer_if.sv
// Bundle between check_sequencer and the circuits under test: run request,
// stimulus buses, the two compared output channels and the result summary.
interface check_sequencer_if #(
  parameter int IN_WIDTH  = 64,
  parameter int DATAWIDTH = 32
);
  logic                 start;
  logic [IN_WIDTH-1:0]  a;
  logic [IN_WIDTH-1:0]  b;
  logic [IN_WIDTH-1:0]  c;
  logic                 stim_valid;
  logic [DATAWIDTH-1:0] zref;
  logic [DATAWIDTH-1:0] zmeas;
  logic [DATAWIDTH-1:0] xref;
  logic [DATAWIDTH-1:0] xmeas;
  logic                 zerr;
  logic                 xerr;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [15:0]          err_count;
  logic [15:0]          first_err_idx;

  modport master (
    input  start, zref, zmeas, xref, xmeas,
    output a, b, c, stim_valid, zerr, xerr, busy, done, pass,
           err_count, first_err_idx
  );

  modport slave (
    output start, zref, zmeas, xref, xmeas,
    input  a, b, c, stim_valid, zerr, xerr, busy, done, pass,
           err_count, first_err_idx
  );
endinterface

// File: rtl/check_sequencer_stim_lfsr.sv
// Stimulus generator: 64-bit Fibonacci LFSR with seed load and step enable,
// producing registered a/b/c vectors resized to IN_WIDTH (zero when cleared).
module stim_lfsr
  import check_pkg::*;
#(
  parameter int          IN_WIDTH = 64,
  parameter logic [63:0] SEED     = 64'h1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                step_i,
  input  logic                clr_i,
  output logic [IN_WIDTH-1:0] a_o,
  output logic [IN_WIDTH-1:0] b_o,
  output logic [IN_WIDTH-1:0] c_o
);

  localparam int EXT_W = (IN_WIDTH > 64) ? IN_WIDTH : 64;

  logic [63:0]         state_q, state_d;
  logic [IN_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;

  // Truncates or zero-extends a 64-bit value onto the stimulus bus width.
  function automatic logic [IN_WIDTH-1:0] fit(input logic [63:0] v);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(v);
    return ext[IN_WIDTH-1:0];
  endfunction

  // Next LFSR state and the vector that state produces on the buses.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = SEED;
    end else if (step_i) begin
      state_d = lfsr_next(state_q);
    end else begin
      state_d = state_q;
    end
    if (clr_i) begin
      a_d = '0;
      b_d = '0;
      c_d = '0;
    end else begin
      a_d = fit(state_d);
      b_d = fit(rot32(state_d));
      c_d = fit(state_d ^ rotl1(state_d));
    end
  end

  // LFSR state and stimulus output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEED;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  assign a_o = a_q;
  assign b_o = b_q;
  assign c_o = c_q;

endmodule

// File: rtl/check_sequencer.sv
// Self-checking sequencer: issues LFSR vectors, tracks the fixed circuit latency
// and scores two output channels. CHECK_SEQUENCER_STOP_ON_ERR_EN ends a run at the first mismatch.
module check_sequencer
  import check_pkg::*;
#(
  parameter int          IN_WIDTH    = 64,
  parameter int          DATAWIDTH   = 32,
  parameter int          LATENCY     = 2,
  parameter int          NUM_VECTORS = 256,
  parameter logic [63:0] SEED        = 64'h1
) (
  input logic              Clk,
  input logic              Rst,
  check_sequencer_if.master io
);

  state_e                   state_q, state_d, nat_d;
  logic [15:0]              vec_idx_q, vec_idx_d;
  logic [15:0]              drain_q, drain_d;
  logic [LATENCY-1:0]       vld_q, vld_d;
  logic [LATENCY-1:0][15:0] idx_q, idx_d;
  logic [ERR_CNT_W-1:0]     err_q, err_d;
  logic [15:0]              first_q, first_d;
  logic                     stim_valid_q, zerr_q, xerr_q, busy_q, done_q, pass_q;
  logic                     run_entry, in_flight_d, stop_hit;
  logic                     cmp_fire, z_mis, x_mis;
  logic [DATAWIDTH-1:0]     zdiff, xdiff;
  logic [ERR_CNT_W:0]       err_sum;

  // The pipeline head carries the vector whose circuit outputs are valid now.
  assign cmp_fire = vld_q[LATENCY-1];
  assign zdiff    = io.zmeas ^ io.zref;
  assign xdiff    = io.xmeas ^ io.xref;
  assign z_mis    = cmp_fire & (|zdiff);
  assign x_mis    = cmp_fire & (|xdiff);

`ifdef CHECK_SEQUENCER_STOP_ON_ERR_EN
  assign stop_hit = z_mis | x_mis;
`else
  assign stop_hit = 1'b0;
`endif

  // Next FSM state; start is only honoured from IDLE or DONE.
  always_comb begin
    nat_d = state_q;
    case (state_q)
      ST_IDLE:  nat_d = io.start ? ST_RUN : ST_IDLE;
      ST_RUN:   nat_d = (vec_idx_q == 16'(NUM_VECTORS - 1)) ? ST_DRAIN : ST_RUN;
      ST_DRAIN: nat_d = (drain_q == 16'(LATENCY - 1)) ? ST_DONE : ST_DRAIN;
      ST_DONE:  nat_d = io.start ? ST_RUN : ST_DONE;
      default:  nat_d = ST_IDLE;
    endcase
    state_d     = stop_hit ? ST_DONE : nat_d;
    run_entry   = (state_d == ST_RUN) && (state_q != ST_RUN);
    in_flight_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  end

  // Vector/drain counters, valid-index pipeline and the scoreboard.
  always_comb begin
    vec_idx_d = (state_q == ST_RUN) ? vec_idx_q + 16'd1 : vec_idx_q;
    drain_d   = (state_q == ST_DRAIN) ? drain_q + 16'd1 : 16'd0;
    if (run_entry) begin
      vec_idx_d = 16'd0;
    end else begin
      vec_idx_d = vec_idx_d;
    end

    vld_d    = '0;
    idx_d    = idx_q;
    idx_d[0] = vec_idx_q;
    for (int i = 1; i < LATENCY; i++) begin
      idx_d[i] = idx_q[i-1];
    end
    if (in_flight_d) begin
      vld_d[0] = stim_valid_q;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end else begin
      vld_d = '0;
    end

    err_d   = err_q;
    first_d = first_q;
    err_sum = {1'b0, err_q} + (ERR_CNT_W + 1)'(z_mis) + (ERR_CNT_W + 1)'(x_mis);
    if (run_entry) begin
      err_d   = '0;
      first_d = NO_ERR_IDX;
    end else if (cmp_fire) begin
      err_d = err_sum[ERR_CNT_W] ? NO_ERR_IDX : err_sum[ERR_CNT_W-1:0];
      if ((z_mis || x_mis) && (first_q == NO_ERR_IDX)) begin
        first_d = idx_q[LATENCY-1];
      end else begin
        first_d = first_q;
      end
    end else begin
      err_d   = err_q;
      first_d = first_q;
    end
  end

  // State, counters, pipeline and registered status outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      vec_idx_q    <= 16'd0;
      drain_q      <= 16'd0;
      vld_q        <= '0;
      idx_q        <= '0;
      err_q        <= '0;
      first_q      <= NO_ERR_IDX;
      stim_valid_q <= 1'b0;
      zerr_q       <= 1'b0;
      xerr_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_idx_q    <= vec_idx_d;
      drain_q      <= drain_d;
      vld_q        <= vld_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      first_q      <= first_d;
      stim_valid_q <= (state_d == ST_RUN);
      zerr_q       <= z_mis;
      xerr_q       <= x_mis;
      busy_q       <= in_flight_d;
      done_q       <= (state_d == ST_DONE);
      pass_q       <= (state_d == ST_DONE) && (err_d == '0);
    end
  end

  stim_lfsr #(
    .IN_WIDTH (IN_WIDTH),
    .SEED     (SEED)
  ) u_stim (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .load_i (run_entry),
    .step_i ((state_q == ST_RUN) && (state_d == ST_RUN)),
    .clr_i  (state_d != ST_RUN),
    .a_o    (io.a),
    .b_o    (io.b),
    .c_o    (io.c)
  );

  assign io.stim_valid    = stim_valid_q;
  assign io.zerr          = zerr_q;
  assign io.xerr          = xerr_q;
  assign io.busy          = busy_q;
  assign io.done          = done_q;
  assign io.pass          = pass_q;
  assign io.err_count     = err_q;
  assign io.first_err_idx = first_q;

endmodule

// File: doc/check_sequencer.md
# check_sequencer

Self-checking sequencer for the assignment's combinational and pipelined test circuits. It replaces free-running stimulus and per-output monitors with one controller. It drives pseudo-random vectors into a reference circuit and its autogenerated twin, tracks the fixed output latency, compares two output channels, and reports a pass/fail summary. It sits between bench infrastructure (clock, reset) and the two circuit instances, and is synthesizable so the same check can run on hardware.

## Interface
- IN_WIDTH, 64, width of each stimulus bus a/b/c
- DATAWIDTH, 32, width of each compared output channel
- LATENCY, 2, cycles from vector issue to valid circuit output (≥1)
- NUM_VECTORS, 256, vectors issued per run (1..65535)
- SEED, 64'h1, nonzero LFSR seed loaded at run start
- Clk  in  1  clock; all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- start  in  1  run request; sampled only in IDLE or DONE
- a, b, c  out  IN_WIDTH each  stimulus to both circuits
- stim_valid  out  1  a/b/c carry a live vector this cycle
- zref, zmeas, xref, xmeas  in  DATAWIDTH each  reference/measured outputs
- zerr, xerr  out  1  registered per-channel mismatch flag
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- pass  out  1  high in DONE when err_count == 0
- err_count  out  16  saturating mismatch count
- first_err_idx  out  16  vector index of first mismatch; 16'hFFFF if none

## Operation
- FSM: IDLE → RUN → DRAIN → DONE. DONE → RUN on start. Rst forces IDLE from any state.
- Reset/IDLE values: a/b/c = 0, stim_valid = 0, zerr = xerr = 0, busy = done = pass = 0, err_count = 0, first_err_idx = 16'hFFFF.
- Entering RUN:
  - LFSR loads SEED.
  - vec_idx = 0, err_count = 0, first_err_idx = FFFF.
- LFSR: 64-bit Fibonacci, taps 64,63,61,60, one step per RUN cycle.
- Stimulus derivation, resized to IN_WIDTH:
  - a = state
  - b = state rotated by 32
  - c = state XOR (state rotated left by 1)
- Outside RUN, a/b/c = 0.
- RUN lasts exactly NUM_VECTORS cycles. stim_valid = 1 throughout. vec_idx increments each cycle.
- Valid/index pipeline is LATENCY deep. A compare fires when the pipeline head is valid.
  - Mismatch test is zmeas != zref and, separately, xmeas != xref, over the full DATAWIDTH.
- err_count adds 0, 1 or 2 per compare cycle (two channels) and saturates at 16'hFFFF.
- first_err_idx latches the pipelined vector index on the first compare cycle with any mismatch. Later mismatches leave it unchanged.
- DRAIN lasts LATENCY cycles with stim_valid = 0, flushing in-flight compares.
- DONE holds all results until start or Rst.
- start in RUN/DRAIN is ignored.

## Timing
- start high at cycle t (IDLE) → RUN at t+1; vector 0 is on a/b/c at t+1.
- Vector k is issued at t+1+k. Its compare occurs at t+1+k+LATENCY.
- zerr/xerr and err_count reflect that compare at t+2+k+LATENCY.
- The last compare is at t+NUM_VECTORS+LATENCY. DONE is entered at t+NUM_VECTORS+LATENCY+1, and done/pass are valid that cycle.
- Restart from DONE: the same 1-cycle start→RUN latency applies, and counters clear on RUN entry.
- Rst mid-run: the next cycle is IDLE with reset values. In-flight pipeline entries are discarded, and no compare fires after Rst.

## Configuration
- CHECK_SEQUENCER_STOP_ON_ERR_EN defined:
  - The first compare cycle with any mismatch transitions directly to DONE on the next cycle.
  - In-flight vectors are discarded. err_count holds that cycle's count (1 or 2). pass = 0.
- Undefined: all NUM_VECTORS vectors are always run and compared.

## Structure
- Package check_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE)
  - LFSR tap constant
  - ERR_CNT_W = 16
  - NO_ERR_IDX = 16'hFFFF
- Sub-module stim_lfsr: seed load, step enable, 64-bit state output, a/b/c derivation.
- FSM, valid pipeline and scoreboard live in check_sequencer.

## Test plan
- Loopback (zmeas=zref, xmeas=xref), NUM_VECTORS=8, LATENCY=2, start at t → done at t+11, pass=1, err_count=0, first_err_idx=FFFF.
- zmeas corrupted only for vector 5 → err_count=1, first_err_idx=5, zerr pulses once at t+9, xerr stays 0.
- Both channels corrupted for vectors 3 and 6 → err_count=4, first_err_idx=3, pass=0.
- Rst asserted at RUN cycle 4, then start → clean rerun. Vector 0 equals the SEED-derived value, and err_count restarts at 0.
- start pulsed during DRAIN → ignored, DONE timing unchanged. A second start from DONE reproduces identical a/b/c sequence and results.
- With STOP_ON_ERR_EN, mismatch on vector 2 → DONE one cycle after the vector-2 compare, err_count=1, stim_valid already 0.
